// File: rtl/trace_dump_sequencer_if.sv
// Capture-RAM read port and UART transmit handshake used by the trace dump sequencer.
// master = sequencer side, slave = RAM mux / UART side.
interface trace_dump_sequencer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int NUM_CH = 3
);
    logic [NUM_CH-1:0] ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] tx_data;
    logic              trmt;
    logic              tx_done;

    modport master (
        output ram_en,
        output ram_addr,
        output tx_data,
        output trmt,
        input  ram_rdata,
        input  tx_done
    );

    modport slave (
        input  ram_en,
        input  ram_addr,
        input  tx_data,
        input  trmt,
        output ram_rdata,
        output tx_done
    );
endinterface

// File: rtl/trace_dump_sequencer.sv
// Streams one captured channel trace (2**ADDR_W samples, oldest first) to the UART.
// Optional trailing CRC-8 byte when DUMP_CRC_EN is defined.
module trace_dump_sequencer #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int NUM_CH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dump,
    input  logic [1:0]          ch_sel,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic                abort,
    output logic                busy,
    output logic                dump_fin,
    output logic                dump_err,
    trace_dump_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_SEND,
        S_WAIT_TX,
`ifdef DUMP_CRC_EN
        S_CRC,
`endif
        S_FIN
    } state_t;

    localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};

    state_t            state;
    logic [1:0]        ch;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W-1:0] addr;
    logic [NUM_CH-1:0] ram_en_r;
    logic [DATA_W-1:0] tx_data_r;
    logic              trmt_r;
    logic              ch_ok;

    function automatic logic [NUM_CH-1:0] onehot(input logic [1:0] c);
        logic [NUM_CH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++)
            r[i] = (32'(c) == i);
        return r;
    endfunction

`ifdef DUMP_CRC_EN
    logic [7:0] crc;

    // CRC-8, poly 0x07, MSB first
    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction
`endif

    assign ch_ok = 32'(ch_sel) < NUM_CH;

    // abort suppresses strobes in the very cycle it is seen
    assign bus.ram_en   = ram_en_r & {NUM_CH{~abort}};
    assign bus.trmt     = trmt_r & ~abort;
    assign bus.ram_addr = addr;
    assign bus.tx_data  = tx_data_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ch        <= '0;
            cnt       <= '0;
            addr      <= '0;
            ram_en_r  <= '0;
            tx_data_r <= '0;
            trmt_r    <= 1'b0;
            busy      <= 1'b0;
            dump_fin  <= 1'b0;
            dump_err  <= 1'b0;
`ifdef DUMP_CRC_EN
            crc       <= '0;
`endif
        end else begin
            ram_en_r <= '0;
            trmt_r   <= 1'b0;
            dump_fin <= 1'b0;
            dump_err <= 1'b0;
            if (state != S_IDLE && abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (dump && ch_ok) begin
                            ch       <= ch_sel;
                            cnt      <= '0;
                            addr     <= start_addr;
                            ram_en_r <= onehot(ch_sel);
                            busy     <= 1'b1;
`ifdef DUMP_CRC_EN
                            crc      <= '0;
`endif
                            state    <= S_READ;
                        end else if (dump) begin
                            dump_err <= 1'b1;
                        end
                    end
                    S_READ: state <= S_LATCH;
                    S_LATCH: begin
                        tx_data_r <= bus.ram_rdata;
                        trmt_r    <= 1'b1;
`ifdef DUMP_CRC_EN
                        crc       <= crc8(crc, bus.ram_rdata[7:0]);
`endif
                        state     <= S_SEND;
                    end
                    S_SEND: state <= S_WAIT_TX;
                    S_WAIT_TX: begin
                        if (bus.tx_done) begin
                            if (cnt == CNT_LAST) begin
`ifdef DUMP_CRC_EN
                                tx_data_r <= DATA_W'(crc);
                                trmt_r    <= 1'b1;
                                state     <= S_CRC;
`else
                                dump_fin  <= 1'b1;
                                state     <= S_FIN;
`endif
                            end else begin
                                cnt      <= cnt + 1'b1;
                                addr     <= addr + 1'b1;
                                ram_en_r <= onehot(ch);
                                state    <= S_READ;
                            end
                        end
                    end
`ifdef DUMP_CRC_EN
                    S_CRC: begin
                        // the strobe cycle itself never completes the byte
                        if (!trmt_r && bus.tx_done) begin
                            dump_fin <= 1'b1;
                            state    <= S_FIN;
                        end
                    end
`endif
                    S_FIN: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trace_dump_sequencer.sv
// Self-checking bench for trace_dump_sequencer: RAM + UART responders,
// expected byte/address stream model and directed scenarios.
module tb_trace_dump_sequencer;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int NC = 3;
    localparam int N  = 512;
`ifdef DUMP_CRC_EN
    localparam int NBYTES = N + 1;
`else
    localparam int NBYTES = N;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dump = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    ch_sel = 2'd0;
    logic [AW-1:0] start_addr = '0;
    logic          busy;
    logic          dump_fin;
    logic          dump_err;

    trace_dump_sequencer_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NC)) bus ();

    trace_dump_sequencer #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NC)) dut (
        .clk        (clk),
        .rst        (rst),
        .dump       (dump),
        .ch_sel     (ch_sel),
        .start_addr (start_addr),
        .abort      (abort),
        .busy       (busy),
        .dump_fin   (dump_fin),
        .dump_err   (dump_err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]    mem [N];
    int            errors = 0;
    int            checks = 0;
    logic [7:0]    exp_b [$];
    logic [AW-1:0] exp_a [$];
    logic [NC-1:0] exp_en = '0;
    logic [7:0]    tx_log [$];
    logic [AW-1:0] addr_log [$];
    int            trmt_cnt = 0;
    int            fin_cnt = 0;
    int            err_cnt = 0;
    int            done_cnt = 0;
    logic [2:0]    sr = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event seen, none expected", nm);
    endtask

    function automatic logic [7:0] crc_ref(input logic [7:0] s [$]);
        logic [7:0] r;
        logic       fb;
        r = 8'h00;
        foreach (s[k])
            for (int b = 7; b >= 0; b--) begin
                fb = r[7] ^ s[k][b];
                r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        return r;
    endfunction

    // RAM: registered read; UART: tx_done pulse 4 clks after trmt
    initial begin
        bus.ram_rdata = '0;
        bus.tx_done   = 1'b0;
    end

    always @(posedge clk) begin
        if (|bus.ram_en) bus.ram_rdata <= mem[bus.ram_addr];
        sr          <= {sr[1:0], bus.trmt};
        bus.tx_done <= sr[2];
        if (sr[2]) done_cnt <= done_cnt + 1;
    end

    // compare process
    always @(negedge clk) begin
        if (!rst) begin
            if (|bus.ram_en) begin
                chk("ram_en", bus.ram_en, exp_en);
                if (exp_a.size() == 0) fail("unexpected_read");
                else begin
                    addr_log.push_back(bus.ram_addr);
                    chk("ram_addr", bus.ram_addr, exp_a.pop_front());
                end
            end
            if (bus.trmt) begin
                trmt_cnt++;
                tx_log.push_back(bus.tx_data);
                if (exp_b.size() == 0) fail("unexpected_trmt");
                else chk("tx_data", bus.tx_data, exp_b.pop_front());
            end
            if (dump_fin) fin_cnt++;
            if (dump_err) err_cnt++;
        end
    end

    task automatic start_dump(input logic [1:0] ch, input logic [AW-1:0] sa, input bit accept);
        logic [AW-1:0] a;
        @(negedge clk);
        if (accept) begin
            exp_a.delete();
            exp_b.delete();
            tx_log.delete();
            addr_log.delete();
            exp_en = '0;
            exp_en[ch] = 1'b1;
            for (int k = 0; k < N; k++) begin
                a = sa + k[AW-1:0];
                exp_a.push_back(a);
                exp_b.push_back(mem[a]);
            end
`ifdef DUMP_CRC_EN
            exp_b.push_back(crc_ref(exp_b));
`endif
        end
        dump       = 1'b1;
        ch_sel     = ch;
        start_addr = sa;
        @(negedge clk);
        dump = 1'b0;
    endtask

    task automatic wait_fin(input int poke_at);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            if (i == poke_at) begin
                dump       = 1'b1;
                ch_sel     = 2'd2;
                start_addr = 9'h0AA;
            end else dump = 1'b0;
            @(negedge clk);
            if (dump_fin) begin
                ok = 1'b1;
                break;
            end
        end
        dump = 1'b0;
        chk("fin_seen", {31'd0, ok}, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int       tb0, fb0, eb0, db0;
        bit       quiet, hit;
        logic [7:0] pin [$];

        pin = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("crc_model_check", crc_ref(pin), 8'hF4);

        // reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.trmt || busy || dump_fin || dump_err || (|bus.ram_en)) quiet = 1'b0;
        end
        chk("idle_quiet", {31'd0, quiet}, 1);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_busy", busy, 0);

        // full dump with wrap, ch 1
        for (int a = 0; a < N; a++) mem[a] = a[7:0];
        tb0 = trmt_cnt;
        fb0 = fin_cnt;
        eb0 = err_cnt;
        start_dump(2'd1, 9'h1F0, 1'b1);
        chk("lat_ram_en", bus.ram_en, 3'b010);
        chk("lat_ram_addr", bus.ram_addr, 9'h1F0);
        chk("lat_busy", busy, 1);
        @(negedge clk);
        chk("lat_no_trmt", bus.trmt, 0);
        @(negedge clk);
        chk("lat_trmt", bus.trmt, 1);
        chk("first_byte", bus.tx_data, 8'hF0);
        wait_fin(300);
        chk("fin_busy", busy, 1);
        @(negedge clk);
        chk("post_busy", busy, 0);
        chk("post_fin", dump_fin, 0);
        chk("trmt_count", trmt_cnt - tb0, NBYTES);
        chk("fin_count", fin_cnt - fb0, 1);
        chk("err_count_busy_dump", err_cnt - eb0, 0);
        chk("bytes_left", exp_b.size(), 0);
        chk("wrap_addr_hi", addr_log[15], 9'h1FF);
        chk("wrap_addr_lo", addr_log[16], 9'h000);
        chk("byte_15", tx_log[15], 8'hFF);
        chk("byte_16", tx_log[16], 8'h00);
        chk("byte_511", tx_log[511], 8'hEF);

        // illegal channel
        eb0 = err_cnt;
        start_dump(2'd3, 9'h000, 1'b0);
        chk("err_pulse", dump_err, 1);
        chk("err_busy", busy, 0);
        chk("err_ram_en", bus.ram_en, 0);
        @(negedge clk);
        chk("err_one_cycle", dump_err, 0);
        chk("err_count", err_cnt - eb0, 1);

        // abort on the 100th tx_done
        for (int a = 0; a < N; a++) mem[a] = 8'(a * 7 + 3);
        tb0 = trmt_cnt;
        fb0 = fin_cnt;
        db0 = done_cnt;
        start_dump(2'd0, 9'h005, 1'b1);
        hit = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (bus.tx_done && (done_cnt - db0) == 100) begin
                hit = 1'b1;
                break;
            end
        end
        chk("abort_point_found", {31'd0, hit}, 1);
        abort = 1'b1;
        exp_a.delete();
        exp_b.delete();
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_trmt", bus.trmt, 0);
        repeat (30) @(negedge clk);
        chk("abort_trmt_count", trmt_cnt - tb0, 100);
        chk("abort_no_fin", fin_cnt - fb0, 0);

        // restart after abort
        tb0 = trmt_cnt;
        fb0 = fin_cnt;
        start_dump(2'd0, 9'h005, 1'b1);
        chk("restart_addr", bus.ram_addr, 9'h005);
        chk("restart_en", bus.ram_en, 3'b001);
        wait_fin(-1);
        @(negedge clk);
        chk("restart_trmt_count", trmt_cnt - tb0, NBYTES);
        chk("restart_fin_count", fin_cnt - fb0, 1);
        chk("restart_byte0", tx_log[0], 8'h26);

`ifdef DUMP_CRC_EN
        for (int a = 0; a < N; a++) mem[a] = 8'h00;
        start_dump(2'd2, 9'h000, 1'b1);
        wait_fin(-1);
        @(negedge clk);
        chk("crc_zero_len", tx_log.size(), N + 1);
        chk("crc_zero", tx_log[N], 8'h00);
        mem[0] = 8'h01;
        start_dump(2'd2, 9'h000, 1'b1);
        wait_fin(-1);
        @(negedge clk);
        chk("crc_one_len", tx_log.size(), N + 1);
        chk("crc_one_left", exp_b.size(), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
